// File: rtl/control_escritura_campos.sv
`default_nettype none
// ============================================================================
//  Module      : control_escritura_campos
//  Description : Turns debounced button levels into cursor moves and
//                hour/minute/second edits, issuing each edited value as a
//                BCD write request on a req/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_escritura_campos #(
    parameter logic [5:0] MAX0  = 6'd23,
    parameter logic [5:0] MAX1  = 6'd59,
    parameter logic [5:0] MAX2  = 6'd59,
    parameter logic [7:0] ADDR0 = 8'h23,
    parameter logic [7:0] ADDR1 = 8'h22,
    parameter logic [7:0] ADDR2 = 8'h21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       programar,
    input  logic       aumento,
    input  logic       disminuye,
    input  logic       derecha,
    input  logic       izquierda,
    input  logic       wr_ack,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [5:0] campo0,
    output logic [5:0] campo1,
    output logic [5:0] campo2,
    output logic [1:0] cursor
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_REQ  = 1'b1;

    logic [0:0] r_state;
    logic       r_aum_prev, r_dis_prev, r_der_prev, r_izq_prev;
    logic [5:0] r_campo0, r_campo1, r_campo2;
    logic [1:0] r_cursor;
    logic       r_wr_req;
    logic [7:0] r_wr_addr, r_wr_data;

    logic       w_p_aum, w_p_dis, w_p_der, w_p_izq;
    logic       w_edit, w_move_r, w_move_l;
    logic [5:0] w_sel_val, w_sel_max, w_new_val;
    logic [7:0] w_sel_addr, w_new_bcd;

    function automatic logic [5:0] f_step(input logic [5:0] v,
                                          input logic [5:0] max,
                                          input logic       up);
        if (up)
            return (v >= max) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    // Repeated subtraction keeps the divider out of the datapath for 0..63
    function automatic logic [7:0] f_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign w_p_aum = aumento   & ~r_aum_prev;
    assign w_p_dis = disminuye & ~r_dis_prev;
    assign w_p_der = derecha   & ~r_der_prev;
    assign w_p_izq = izquierda & ~r_izq_prev;

    assign w_move_r = programar & w_p_der & ~w_p_izq;
    assign w_move_l = programar & w_p_izq & ~w_p_der;
    assign w_edit   = programar & (r_state == c_ST_IDLE) & (w_p_aum ^ w_p_dis);

    always_comb begin
        w_sel_val  = r_campo2;
        w_sel_max  = MAX2;
        w_sel_addr = ADDR2;
        case (r_cursor)
            2'd0: begin
                w_sel_val  = r_campo0;
                w_sel_max  = MAX0;
                w_sel_addr = ADDR0;
            end
            2'd1: begin
                w_sel_val  = r_campo1;
                w_sel_max  = MAX1;
                w_sel_addr = ADDR1;
            end
            default: ;
        endcase
        w_new_val = f_step(w_sel_val, w_sel_max, w_p_aum);
        w_new_bcd = f_bcd(w_new_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_aum_prev <= 1'b1;
            r_dis_prev <= 1'b1;
            r_der_prev <= 1'b1;
            r_izq_prev <= 1'b1;
            r_campo0   <= 6'd0;
            r_campo1   <= 6'd0;
            r_campo2   <= 6'd0;
            r_cursor   <= 2'd0;
            r_wr_req   <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 8'h00;
        end else begin
            r_aum_prev <= aumento;
            r_dis_prev <= disminuye;
            r_der_prev <= derecha;
            r_izq_prev <= izquierda;

            if (!programar)
                r_cursor <= 2'd0;
            else if (w_move_r)
                r_cursor <= (r_cursor >= 2'd2) ? 2'd0 : r_cursor + 2'd1;
            else if (w_move_l)
                r_cursor <= (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_edit) begin
                        case (r_cursor)
                            2'd0:    r_campo0 <= w_new_val;
                            2'd1:    r_campo1 <= w_new_val;
                            default: r_campo2 <= w_new_val;
                        endcase
                        r_wr_addr <= w_sel_addr;
                        r_wr_data <= w_new_bcd;
                        r_wr_req  <= 1'b1;
                        r_state   <= c_ST_REQ;
                    end
                end
                default: begin
                    if (wr_ack) begin
                        r_wr_req <= 1'b0;
                        r_state  <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign wr_req  = r_wr_req;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign campo0  = r_campo0;
    assign campo1  = r_campo1;
    assign campo2  = r_campo2;
    assign cursor  = r_cursor;

endmodule
`default_nettype wire

// File: doc/control_escritura_campos.md
Name: control_escritura_campos

Overview:
- Sits directly downstream of the button metastability/debounce stage.
- Consumes the clean aumento/disminuye/derecha/izquierda levels and converts them into cursor movement and field edits for three time fields (hour, minute, second).
- Every edited value is issued as a BCD write request to the RTC bus interface through a req/ack handshake.
- Current values and cursor position go to the display path.

Parameters:
- MAX0, 23, wrap limit of field 0 (hours)
- MAX1, 59, wrap limit of field 1 (minutes)
- MAX2, 59, wrap limit of field 2 (seconds)
- ADDR0, 8'h23, RTC register address for field 0
- ADDR1, 8'h22, RTC register address for field 1
- ADDR2, 8'h21, RTC register address for field 2

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- programar  input  1  edit mode enable; edits and cursor moves accepted only when 1
- aumento  input  1  debounced increment button level
- disminuye  input  1  debounced decrement button level
- derecha  input  1  debounced cursor-right button level
- izquierda  input  1  debounced cursor-left button level
- wr_ack  input  1  write accepted by RTC interface
- wr_req  output  1  write request, held until acknowledged
- wr_addr  output  8  register address of pending write
- wr_data  output  8  BCD value of pending write (tens[7:4], units[3:0])
- campo0  output  6  binary hours
- campo1  output  6  binary minutes
- campo2  output  6  binary seconds
- cursor  output  2  selected field, 0..2

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values:
  - campo0/1/2 = 0, cursor = 0.
  - wr_req = 0, wr_addr = 0, wr_data = 0.
  - FSM = IDLE.
  - Edge-detect history registers = 1, so a button held through reset does not generate a press.
- Edge detection:
  - pulse_x = x & ~x_prev; x_prev is registered every cycle.
  - One press produces exactly one action, regardless of hold length.
- Cursor movement:
  - Applies only when programar = 1.
  - derecha pulse: cursor+1, wrapping 2 -> 0.
  - izquierda pulse: cursor-1, wrapping 0 -> 2.
  - derecha and izquierda pulses in the same cycle: no move.
  - Updated at the edge after the pulse cycle.
- Field edit:
  - Applies only when programar = 1 and FSM = IDLE.
  - aumento pulse: field[cursor]+1, wrapping MAXn -> 0.
  - disminuye pulse: field[cursor]-1, wrapping 0 -> MAXn.
  - aumento and disminuye pulses in the same cycle: no change and no write.
  - An edit and a cursor move in the same cycle: the edit applies to the pre-move cursor field; the cursor moves at the same edge.
- Write FSM:
  - IDLE: on an accepted edit at edge n, the new field value, wr_addr = ADDRn and wr_data = BCD(new value) all register at edge n, with wr_req = 1 from edge n. Latency from the pulse cycle is 1 cycle.
  - REQ: hold wr_req, wr_addr and wr_data stable until wr_ack = 1 is sampled. At that edge wr_req goes to 0 and the FSM returns to IDLE.
  - wr_ack is ignored in IDLE.
- Busy rule: in REQ, aumento/disminuye pulses are dropped (not queued). Cursor moves are still accepted.
- programar = 0:
  - All button pulses are ignored and cursor is held at 0.
  - A pending REQ still completes normally.
  - Field values keep their last values.
- BCD conversion: value 0..59 maps to tens = value/10, units = value%10; combinational from the new value, registered into wr_data.
- Reset mid-REQ: the request is dropped immediately (wr_req = 0 at the reset edge) and all fields return to 0.

Test Plan:
- Reset with aumento held high, release rst, keep aumento high -> no edit and wr_req stays 0; release then press aumento -> campo0 = 1, wr_req = 1, wr_addr = 8'h23, wr_data = 8'h01 one cycle after the press.
- programar = 1, cursor = 1, campo1 = 59, press aumento -> campo1 = 0 and wr_data = 8'h00; with campo1 = 0, press disminuye -> campo1 = 59 and wr_data = 8'h59.
- Cursor at 0, press izquierda -> cursor = 2; press derecha three times -> cursor = 2; press derecha and izquierda in the same cycle -> cursor unchanged.
- wr_ack held 0 for 5 cycles after a request, press aumento twice during that time -> wr_req, wr_addr and wr_data stable, field changes only once; assert wr_ack -> wr_req = 0 on the next edge.
- Cursor = 0, campo0 = 5, press aumento and derecha in the same cycle -> campo0 = 6, cursor = 1, wr_addr = 8'h23.
- programar = 0, press all buttons -> no field change, cursor = 0, no wr_req; assert rst during REQ -> wr_req = 0 and campo0/1/2 = 0 at the next edge.
